// File: rtl/bus_port_fifo_bank.sv
// Device-side endpoint bank for the bus generator/arbiter. Every bus/device channel owns a TX
// FIFO (host writes, bus drains via pndng/pop/D_pop) and an RX FIFO (bus pushes, host reads),
// with RX destination filtering, sticky overflow/underflow flags and saturating drop counters.
module bus_port_fifo_bank #(
  parameter int unsigned bits      = 1,
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter bit          filter_en = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  output logic [bits-1:0][drvrs-1:0]                pndng,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
  input  logic [bits-1:0][drvrs-1:0]                pop,
  input  logic [bits-1:0][drvrs-1:0]                push,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push,
  input  logic [bits*drvrs-1:0]                     tx_wr,
  input  logic [bits*drvrs*pckg_sz-1:0]             tx_data,
  output logic [bits*drvrs-1:0]                     tx_full,
  input  logic [bits*drvrs-1:0]                     rx_rd,
  output logic [bits*drvrs*pckg_sz-1:0]             rx_data,
  output logic [bits*drvrs-1:0]                     rx_empty,
  output logic [bits*drvrs-1:0]                     err_ovf,
  output logic [bits*drvrs-1:0]                     err_udf,
  output logic [bits*drvrs*8-1:0]                   drop_cnt
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(depth);

  typedef logic [pckg_sz-1:0] word_t;

  for (genvar gb = 0; gb < bits; gb++) begin : g_bus
    for (genvar gd = 0; gd < drvrs; gd++) begin : g_dev
      localparam int unsigned Ch    = gb * drvrs + gd;
      localparam logic [7:0]  DevId = 8'(gd);

      word_t           tx_mem_q [depth];
      logic [PtrW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
      logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
      logic            tx_do_wr, tx_do_rd;

      word_t           rx_mem_q [depth];
      logic [PtrW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
      logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
      logic            rx_do_wr, rx_do_rd, rx_filt_ok, rx_drop;

      logic            ovf_q, ovf_d, udf_q, udf_d;
      logic [7:0]      drop_q, drop_d;

      // Accept/advance decisions, pointer/count next-state and sticky error tracking.
      always_comb begin
        // A read frees a slot in the same cycle, so a write at full still lands if paired.
        tx_do_rd = pop[gb][gd] && (tx_cnt_q != '0);
        tx_do_wr = tx_wr[Ch] && ((tx_cnt_q != CntFull) || tx_do_rd);
        tx_wptr_d = tx_do_wr ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d = tx_do_rd ? tx_rptr_q + 1'b1 : tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_do_wr && !tx_do_rd) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end else if (!tx_do_wr && tx_do_rd) begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end

        // Filtering looks only at the device index; the bus index plays no part.
        rx_filt_ok = !filter_en || (D_push[gb][gd][pckg_sz-1 -: 8] == DevId) ||
                     (D_push[gb][gd][pckg_sz-1 -: 8] == broadcast);
        rx_do_rd = rx_rd[Ch] && (rx_cnt_q != '0);
        rx_do_wr = push[gb][gd] && rx_filt_ok && ((rx_cnt_q != CntFull) || rx_do_rd);
        rx_drop  = push[gb][gd] && !rx_do_wr;
        rx_wptr_d = rx_do_wr ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d = rx_do_rd ? rx_rptr_q + 1'b1 : rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_do_wr && !rx_do_rd) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end else if (!rx_do_wr && rx_do_rd) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end

        ovf_d  = ovf_q | (tx_wr[Ch] && !tx_do_wr);
        udf_d  = udf_q | (pop[gb][gd] && (tx_cnt_q == '0)) | (rx_rd[Ch] && (rx_cnt_q == '0));
        drop_d = (rx_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
      end

      // Pointer, occupancy and flag registers.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tx_wptr_q <= '0;
          tx_rptr_q <= '0;
          tx_cnt_q  <= '0;
          rx_wptr_q <= '0;
          rx_rptr_q <= '0;
          rx_cnt_q  <= '0;
          ovf_q     <= 1'b0;
          udf_q     <= 1'b0;
          drop_q    <= '0;
        end else begin
          tx_wptr_q <= tx_wptr_d;
          tx_rptr_q <= tx_rptr_d;
          tx_cnt_q  <= tx_cnt_d;
          rx_wptr_q <= rx_wptr_d;
          rx_rptr_q <= rx_rptr_d;
          rx_cnt_q  <= rx_cnt_d;
          ovf_q     <= ovf_d;
          udf_q     <= udf_d;
          drop_q    <= drop_d;
        end
      end

      // Storage arrays; cleared on reset so heads read as zero afterwards.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tx_mem_q <= '{default: '0};
          rx_mem_q <= '{default: '0};
        end else begin
          if (tx_do_wr) tx_mem_q[tx_wptr_q] <= tx_data[Ch*pckg_sz +: pckg_sz];
          if (rx_do_wr) rx_mem_q[rx_wptr_q] <= D_push[gb][gd];
        end
      end

      assign pndng[gb][gd]                 = (tx_cnt_q != '0);
      assign D_pop[gb][gd]                 = tx_mem_q[tx_rptr_q];
      assign tx_full[Ch]                   = (tx_cnt_q == CntFull);
      assign rx_data[Ch*pckg_sz +: pckg_sz] = rx_mem_q[rx_rptr_q];
      assign rx_empty[Ch]                  = (rx_cnt_q == '0);
      assign err_ovf[Ch]                   = ovf_q;
      assign err_udf[Ch]                   = udf_q;
      assign drop_cnt[Ch*8 +: 8]           = drop_q;
    end
  end

endmodule

// File: tb/tb_bus_port_fifo_bank.sv
// Bench for bus_port_fifo_bank: a 2-bus x 4-device filtered bank (channels 0..7) and a 1-bus
// unfiltered bank (channels 8..11), checked every cycle against queue-based reference FIFOs.
module tb_bus_port_fifo_bank;
  localparam int NC    = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Filtered bank, bits=2 drvrs=4
  logic [1:0][3:0]        a_pndng, a_pop, a_push;
  logic [1:0][3:0][15:0]  a_dpop, a_dpush;
  logic [7:0]             a_txwr, a_txfull, a_rxrd, a_rxempty, a_ovf, a_udf;
  logic [127:0]           a_txdata, a_rxdata;
  logic [63:0]            a_drop;
  // Unfiltered bank, bits=1 drvrs=4
  logic [0:0][3:0]        n_pndng, n_pop, n_push;
  logic [0:0][3:0][15:0]  n_dpop, n_dpush;
  logic [3:0]             n_txwr, n_txfull, n_rxrd, n_rxempty, n_ovf, n_udf;
  logic [63:0]            n_txdata, n_rxdata;
  logic [31:0]            n_drop;

  bus_port_fifo_bank #(.bits(2), .drvrs(4), .pckg_sz(16), .depth(8), .broadcast(8'hFF),
                       .filter_en(1'b1)) dut (
    .clk(clk), .reset(reset), .pndng(a_pndng), .D_pop(a_dpop), .pop(a_pop), .push(a_push),
    .D_push(a_dpush), .tx_wr(a_txwr), .tx_data(a_txdata), .tx_full(a_txfull), .rx_rd(a_rxrd),
    .rx_data(a_rxdata), .rx_empty(a_rxempty), .err_ovf(a_ovf), .err_udf(a_udf),
    .drop_cnt(a_drop)
  );

  bus_port_fifo_bank #(.bits(1), .drvrs(4), .pckg_sz(16), .depth(8), .broadcast(8'hFF),
                       .filter_en(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .pndng(n_pndng), .D_pop(n_dpop), .pop(n_pop), .push(n_push),
    .D_push(n_dpush), .tx_wr(n_txwr), .tx_data(n_txdata), .tx_full(n_txfull), .rx_rd(n_rxrd),
    .rx_data(n_rxdata), .rx_empty(n_rxempty), .err_ovf(n_ovf), .err_udf(n_udf),
    .drop_cnt(n_drop)
  );

  // Per-channel stimulus
  logic        s_pop [NC];
  logic        s_push[NC];
  logic        s_txwr[NC];
  logic        s_rxrd[NC];
  logic [15:0] s_dpush[NC];
  logic [15:0] s_txdata[NC];

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      a_pop[c/4][c%4]   = s_pop[c];
      a_push[c/4][c%4]  = s_push[c];
      a_dpush[c/4][c%4] = s_dpush[c];
      a_txwr[c]         = s_txwr[c];
      a_rxrd[c]         = s_rxrd[c];
      a_txdata[c*16 +: 16] = s_txdata[c];
    end
    for (int c = 0; c < 4; c++) begin
      n_pop[0][c]   = s_pop[c+8];
      n_push[0][c]  = s_push[c+8];
      n_dpush[0][c] = s_dpush[c+8];
      n_txwr[c]     = s_txwr[c+8];
      n_rxrd[c]     = s_rxrd[c+8];
      n_txdata[c*16 +: 16] = s_txdata[c+8];
    end
  end

  // Reference model: plain queues plus flags
  logic [15:0] txq[NC][$];
  logic [15:0] rxq[NC][$];
  bit          m_ovf[NC];
  bit          m_udf[NC];
  int          m_drop[NC];

  int tests = 0;
  int fails = 0;

  function automatic int dev_of(int c);
    return (c < 8) ? c % 4 : c - 8;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      txq[c].delete();
      rxq[c].delete();
      m_ovf[c]  = 1'b0;
      m_udf[c]  = 1'b0;
      m_drop[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      int   n;
      bit   rd, wr, ok;
      logic [7:0] id;
      n  = txq[c].size();
      rd = s_pop[c] && n > 0;
      wr = s_txwr[c] && (n < DEPTH || rd);
      if (s_pop[c] && !rd) m_udf[c] = 1'b1;
      if (s_txwr[c] && !wr) m_ovf[c] = 1'b1;
      if (rd) void'(txq[c].pop_front());
      if (wr) txq[c].push_back(s_txdata[c]);
      n  = rxq[c].size();
      id = s_dpush[c][15:8];
      ok = (c >= 8) || id == 8'(dev_of(c)) || id == 8'hFF;
      rd = s_rxrd[c] && n > 0;
      wr = s_push[c] && ok && (n < DEPTH || rd);
      if (s_rxrd[c] && !rd) m_udf[c] = 1'b1;
      if (s_push[c] && !wr && m_drop[c] < 255) m_drop[c]++;
      if (rd) void'(rxq[c].pop_front());
      if (wr) rxq[c].push_back(s_dpush[c]);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      s_pop[c] = 0; s_push[c] = 0; s_txwr[c] = 0; s_rxrd[c] = 0;
      s_dpush[c] = '0; s_txdata[c] = '0;
    end
  endtask

  task automatic get_obs(input int c, output logic pnd, output logic full, output logic emp,
                         output logic ovf, output logic udf, output logic [7:0] drop,
                         output logic [15:0] dpop, output logic [15:0] rxd);
    if (c < 8) begin
      pnd = a_pndng[c/4][c%4]; dpop = a_dpop[c/4][c%4];
      full = a_txfull[c]; emp = a_rxempty[c]; ovf = a_ovf[c]; udf = a_udf[c];
      drop = a_drop[c*8 +: 8]; rxd = a_rxdata[c*16 +: 16];
    end else begin
      pnd = n_pndng[0][c-8]; dpop = n_dpop[0][c-8];
      full = n_txfull[c-8]; emp = n_rxempty[c-8]; ovf = n_ovf[c-8]; udf = n_udf[c-8];
      drop = n_drop[(c-8)*8 +: 8]; rxd = n_rxdata[(c-8)*16 +: 16];
    end
  endtask

  task automatic chk(input string tag, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, c, got, exp);
    end
  endtask

  task automatic check_all();
    logic pnd, full, emp, ovf, udf;
    logic [7:0] drop;
    logic [15:0] dpop, rxd;
    for (int c = 0; c < NC; c++) begin
      get_obs(c, pnd, full, emp, ovf, udf, drop, dpop, rxd);
      chk("pndng", c, 32'(pnd), 32'(txq[c].size() > 0));
      chk("tx_full", c, 32'(full), 32'(txq[c].size() == DEPTH));
      chk("rx_empty", c, 32'(emp), 32'(rxq[c].size() == 0));
      chk("err_ovf", c, 32'(ovf), 32'(m_ovf[c]));
      chk("err_udf", c, 32'(udf), 32'(m_udf[c]));
      chk("drop_cnt", c, 32'(drop), 32'(m_drop[c]));
      if (txq[c].size() > 0) chk("D_pop", c, 32'(dpop), 32'(txq[c][0]));
      if (rxq[c].size() > 0) chk("rx_data", c, 32'(rxd), 32'(rxq[c][0]));
    end
  endtask

  // Apply current stimulus for one edge, then compare everything at posedge+1.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    clear_stim();
    check_all();
  endtask

  initial begin
    logic pnd, full, emp, ovf, udf;
    logic [7:0] drop;
    logic [15:0] dpop, rxd;
    logic [15:0] fv[3];
    fv[0] = 16'h02AB; fv[1] = 16'hFFCD; fv[2] = 16'h03EF;

    clear_stim();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    for (int c = 0; c < NC; c++) begin
      get_obs(c, pnd, full, emp, ovf, udf, drop, dpop, rxd);
      chk("rst_D_pop", c, 32'(dpop), 32'h0);
      chk("rst_rx_data", c, 32'(rxd), 32'h0);
    end

    // TX ordering and pointer wrap on channel 0
    for (int i = 0; i < 12; i++) begin
      s_txwr[0] = 1'b1;
      s_txdata[0] = 16'(32'h0101 + i);
      s_pop[0] = (i > 0);
      tick();
    end
    get_obs(0, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("tx_order_last", 0, 32'(dpop), 32'h010C);
    chk("tx_order_no_ovf", 0, 32'(ovf), 32'h0);
    s_pop[0] = 1'b1;
    tick();

    // TX overflow on channel 1
    for (int i = 0; i < 9; i++) begin
      s_txwr[1] = 1'b1;
      s_txdata[1] = 16'(32'h1101 + i);
      tick();
      get_obs(1, pnd, full, emp, ovf, udf, drop, dpop, rxd);
      if (i == 7) chk("tx_full_after_8", 1, 32'(full), 32'h1);
    end
    get_obs(1, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("ovf_after_9", 1, 32'(ovf), 32'h1);
    s_txwr[1] = 1'b1;
    s_txdata[1] = 16'h11AA;
    s_pop[1] = 1'b1;
    tick();
    get_obs(1, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("full_after_wr_pop", 1, 32'(full), 32'h1);
    repeat (7) begin
      s_pop[1] = 1'b1;
      tick();
    end
    get_obs(1, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("wr_pop_word_last", 1, 32'(dpop), 32'h11AA);
    s_pop[1] = 1'b1;
    tick();

    // RX filter: device 2 on filtered bank (ch2) and unfiltered bank (ch10)
    for (int i = 0; i < 3; i++) begin
      s_push[2] = 1'b1;  s_dpush[2] = fv[i];
      s_push[10] = 1'b1; s_dpush[10] = fv[i];
      tick();
    end
    get_obs(2, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("filt_drop", 2, 32'(drop), 32'h1);
    chk("filt_head", 2, 32'(rxd), 32'h02AB);
    get_obs(10, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("nofilt_drop", 10, 32'(drop), 32'h0);
    repeat (3) begin
      s_rxrd[2] = 1'b1;
      s_rxrd[10] = 1'b1;
      tick();
    end

    // RX saturation on channel 3 (device 3)
    for (int i = 0; i < 8; i++) begin
      s_push[3] = 1'b1;
      s_dpush[3] = 16'(32'h0300 + i);
      tick();
    end
    repeat (300) begin
      s_push[3] = 1'b1;
      s_dpush[3] = 16'h03EE;
      tick();
    end
    get_obs(3, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("sat_drop", 3, 32'(drop), 32'd255);
    chk("sat_head", 3, 32'(rxd), 32'h0300);
    repeat (8) begin
      s_rxrd[3] = 1'b1;
      tick();
    end

    // Multi-bus independence: all 8 filtered-bank channels at once
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 8; c++) begin
        s_txwr[c] = 1'b1;
        s_txdata[c] = 16'(32'hC000 + c * 256 + i);
      end
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      get_obs(c, pnd, full, emp, ovf, udf, drop, dpop, rxd);
      chk("mb_head", c, 32'(dpop), 32'hC000 + 32'(c * 256));
    end
    repeat (4) begin
      for (int c = 0; c < 8; c++) s_pop[c] = 1'b1;
      tick();
    end

    // Randomized traffic on every channel
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NC; c++) begin
        logic [7:0] id;
        int r;
        r = int'($urandom_range(0, 3));
        id = (r == 0) ? 8'(dev_of(c)) : (r == 1) ? 8'hFF : 8'($urandom);
        s_txwr[c]   = ($urandom_range(0, 2) != 0);
        s_txdata[c] = 16'($urandom);
        s_pop[c]    = 1'($urandom_range(0, 1));
        s_push[c]   = 1'($urandom_range(0, 1));
        s_dpush[c]  = {id, 8'($urandom)};
        s_rxrd[c]   = 1'($urandom_range(0, 1));
      end
      tick();
    end

    // Reset asserted mid-stream with words queued on channel 0
    for (int i = 0; i < 3; i++) begin
      s_txwr[0] = 1'b1;
      s_txdata[0] = 16'(32'hA000 + i);
      s_push[0] = 1'b1;
      s_dpush[0] = 16'(32'h0050 + i);
      tick();
    end
    reset = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      get_obs(c, pnd, full, emp, ovf, udf, drop, dpop, rxd);
      chk("async_rst_pndng", c, 32'(pnd), 32'h0);
      chk("async_rst_rx_empty", c, 32'(emp), 32'h1);
      chk("async_rst_drop", c, 32'(drop), 32'h0);
      chk("async_rst_D_pop", c, 32'(dpop), 32'h0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    s_pop[0] = 1'b1;
    tick();
    get_obs(0, pnd, full, emp, ovf, udf, drop, dpop, rxd);
    chk("udf_after_rst", 0, 32'(udf), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_port_fifo_bank.md
# bus_port_fifo_bank

Synthesizable device-side endpoint bank for the bus generator/arbiter (`bs_gnrtr_n_rbtr`), replacing the behavioural per-device driver with real buffering. Each bus channel gets a TX FIFO, which host logic fills and the bus drains through `pndng`/`pop`/`D_pop`, and an RX FIFO, which the bus fills through `push`/`D_push` and host logic drains. Generalised over bus count, device count, packet size and FIFO depth. Adds RX destination filtering, overflow/underflow flags and saturating drop counters.

## Interface
- `bits`, default 1: number of parallel buses.
- `drvrs`, default 4: devices per bus.
- `pckg_sz`, default 16: packet width. Destination id = `[pckg_sz-1 -: 8]`.
- `depth`, default 8: entries per FIFO. Power of two, ≥2.
- `broadcast`, default 8'hFF: id accepted by every device.
- `filter_en`, default 1: 1 = drop RX packets whose id ≠ device index and ≠ `broadcast`.
- Channel index `c = b*drvrs + d`, where N = `bits*drvrs`. Flat host buses are packed with channel c at slice `[c*W +: W]`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `pndng` out `[bits-1:0][drvrs-1:0]`: TX FIFO non-empty.
- `D_pop` out `[bits-1:0][drvrs-1:0][pckg_sz-1:0]`: TX head word, show-ahead.
- `pop` in `[bits-1:0][drvrs-1:0]`: bus consumed TX head.
- `push` in `[bits-1:0][drvrs-1:0]`: bus delivers `D_push`.
- `D_push` in `[bits-1:0][drvrs-1:0][pckg_sz-1:0]`: delivered packet.
- `tx_wr` in N: host write strobe.
- `tx_data` in N*pckg_sz: host write data.
- `tx_full` out N: TX FIFO full.
- `rx_rd` in N: host read strobe.
- `rx_data` out N*pckg_sz: RX head word, show-ahead.
- `rx_empty` out N: RX FIFO empty.
- `err_ovf` out N: sticky. Set on a TX write dropped because the FIFO is full.
- `err_udf` out N: sticky. Set on a `pop` or `rx_rd` to an empty FIFO.
- `drop_cnt` out N*8: per-channel count of RX drops (full or filtered). Saturates at 255.

## Operation
- All channels are independent and identical.
- FIFOs:
  - Circular buffer with `$clog2(depth)`-bit read/write pointers and a `$clog2(depth)+1`-bit occupancy count.
  - Pointers wrap from `depth-1` to 0.
  - Head word is driven combinationally from memory at the read pointer (first-word fall-through).
- TX write:
  - `tx_wr` with count < depth: store the word.
  - `tx_wr` at full and no `pop`: word discarded; `err_ovf` set.
  - `tx_wr` at full with `pop` in the same cycle: write accepted, count unchanged.
- TX read:
  - `pop` with `pndng`=1: head advances.
  - `pop` with `pndng`=0: ignored; `err_udf` set.
- RX accept: `push`=1, then filter check, then capacity check.
  - Filter fails (`filter_en`=1, id ∉ {d, `broadcast`}): drop and increment `drop_cnt`.
  - RX full and no `rx_rd` in the same cycle: drop and increment `drop_cnt`.
  - Otherwise: store.
  - Filter uses device index d only; bus index b is ignored.
- RX read:
  - `rx_rd` with data: head advances.
  - `rx_rd` when empty: ignored; `err_udf` set.
- Simultaneous write and read on an empty FIFO: the write is accepted, the read is ignored and flagged.
- `drop_cnt` holds at 255.
- Flags clear only on reset.

## Timing
- Reset (async assert, synchronous deassert expected from the system):
  - All FIFOs empty; pointers 0.
  - `pndng`=0, `tx_full`=0, `rx_empty`=1.
  - `D_pop`/`rx_data`=0, because memory is cleared on reset.
  - `err_*`=0, `drop_cnt`=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- TX latency: `tx_wr` sampled at edge t makes `pndng`=1 and `D_pop`=data valid after edge t (cycle t+1).
- TX pop: `pop` at edge t presents the next word, or drops `pndng`, after edge t.
- RX latency: `push` at edge t makes `rx_empty`=0 and `rx_data` valid after edge t.
- Status outputs are registered-state derived: `tx_full`, `rx_empty`, `pndng` reflect count after the last edge and never depend combinationally on strobes.
- Full throughput: one write and one read per channel per cycle, sustained.

## Test plan
- **Reset values:** reset low mid-stream with 3 words queued → same cycle: `pndng`=0, `rx_empty`=1, `drop_cnt`=0; after release, the first `pop` sets `err_udf`.
- **TX ordering and wrap:** depth=8, write 0x0101..0x010C in 12 cycles while popping from the 2nd cycle → `D_pop` sequence exact, pointers wrap, no `err_ovf`.
- **TX overflow:** 9 writes with no pop → `tx_full`=1 after the 8th, 9th word lost, `err_ovf`=1. Then a write plus pop at full → count stays 8, new word is last out.
- **RX filter:** device 2, `D_push`=0x02AB, 0xFFCD, 0x03EF → first two stored, `drop_cnt`=1. With `filter_en`=0 all three are stored.
- **RX saturation:** 300 pushes to a full RX with no reads → `drop_cnt`=255, contents unchanged.
- **Multi-bus independence:** `bits`=2, `drvrs`=4, all 8 channels loaded with distinct data at once → no cross-channel leakage; each `D_pop[b][d]` matches its own writes.
